quat_interp_pipe: RTL and testbench
===================================

QUAT_INTERP_PIPE -- requirements
Module: quat_interp_pipe

Interface
REQ-001 SHALL have parameter PIX_W, default 8: sample bit width.
REQ-002 SHALL have parameter LANES, default 4: independent pixel windows per beat.
REQ-003 SHALL have parameter ROWS, default 4: beats per block; ROWS >= 1.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port start  in  1  block start request, sampled in IDLE only.
REQ-008 SHALL have port best  in  4  best half-pel index 0..8, latched at start.
REQ-009 SHALL have port rnd_mode  in  1  latched at start: 0 = round-half-up average, 1 = truncating average.
REQ-010 SHALL have port in_valid  in  1  input beat valid.
REQ-011 SHALL have port in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-012 SHALL have port int_pix  in  LANES*9*PIX_W  integer 3x3 per lane; lane l, sample k at bits [(l*9+k)*PIX_W +: PIX_W] (same packing for all buses).
REQ-013 SHALL have port half_cand  in  LANES*9*PIX_W  half-pel 3x3 candidates per lane.
REQ-014 SHALL have port half_pix  in  LANES*8*PIX_W  outer half-pel ring per lane, 8 samples.
REQ-015 SHALL have port out_valid  out  1  output beat valid.
REQ-016 SHALL have port out_ready  in  1  downstream accept.
REQ-017 SHALL have port quat  out  LANES*9*PIX_W  quarter-pel 3x3 per lane.
REQ-018 SHALL have port out_last  out  1  qualifies the ROWS-th output beat of a block.
REQ-019 SHALL have port done  out  1  one-cycle pulse at block completion.
REQ-020 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-021 SHALL have port best_err  out  1  sticky: latched best > 8; cleared by next accepted start or rst.

Function
REQ-022 Per lane, a 5x5 half-pel grid G(r,c) SHALL be formed: int_pix[k] at (2*(k/3), 2*(k%3)); half_cand[k] at (1+k/3, 1+k%3) except (2,2), which is int_pix[4]; half_pix[0..7] at (0,1),(0,3),(1,4),(3,4),(4,3),(4,1),(3,0),(1,0).
REQ-023 With b = latched best, C = half_cand[b], (rb,cb) = (1+b/3, 1+b%3): quat[j] for j != 4 SHALL be avg(G(rb-1+j/3, cb-1+j%3), C); quat[4] SHALL equal C.
REQ-024 avg(a,c) SHALL be (a+c+1)>>1 when rnd_mode=0, (a+c)>>1 when rnd_mode=1, computed at PIX_W+1 bits; result never exceeds 2^PIX_W-1.
REQ-025 Latched best > 8 SHALL be processed as best = 0 and SHALL set best_err.
REQ-026 FSM states IDLE, RUN, DRAIN: IDLE->RUN on start (latch best, rnd_mode, clear beat counters); RUN->DRAIN on the ROWS-th accepted input beat; DRAIN->IDLE on the transfer of the out_last beat.
REQ-027 start SHALL be ignored outside IDLE; in_ready SHALL be 0 in IDLE and DRAIN.
REQ-028 Pipeline is two register stages (neighbour select, average); advance = !out_valid || out_ready; in_ready = (state==RUN) && advance.
REQ-029 Latency SHALL be exactly 2 cycles from input acceptance to out_valid with out_ready held 1; throughput one beat per cycle.
REQ-030 While out_valid && !out_ready, quat, out_last and out_valid SHALL hold stable and no input SHALL be accepted.
REQ-031 Input bubbles (in_valid=0) SHALL propagate as bubbles, never as duplicate beats.
REQ-032 done SHALL pulse in the cycle after the out_last transfer, coincident with first IDLE cycle; start may be accepted in that same cycle.
REQ-033 Beat counters SHALL count 0..ROWS-1 and wrap only via a new start.

Reset
REQ-034 rst SHALL force state IDLE, out_valid=0, out_last=0, done=0, busy=0, best_err=0, in_ready=0, quat=0, both pipeline valids 0, counters 0.
REQ-035 rst mid-block SHALL discard all in-flight beats; no done pulse for the aborted block.

Verification
REQ-036 best=4, rnd_mode=0, half_cand all 10 except [4]=20, ROWS=4 -> quat[4]=20, others 15, four beats, out_last on 4th, done one cycle later.
REQ-037 best=0, int_pix[0]=255, half_cand[0]=0, rnd_mode=0 then 1 -> quat[0]=128 then 127.
REQ-038 best=9 -> best_err=1, outputs identical to best=0 run; next start with best=2 clears best_err.
REQ-039 out_ready low 3 cycles mid-block -> quat stable, in_ready=0, no beats lost or duplicated.
REQ-040 rst asserted after 2 accepted beats -> next cycle out_valid=0, busy=0, no done; subsequent block runs normally.
REQ-041 start asserted during RUN -> ignored; block still ends after exactly ROWS beats.

Source files
------------

// File: rtl/quat_interp_pipe.sv
// Quarter-pel interpolation pipeline: picks the 3x3 neighbourhood around the best
// half-pel position on a 5x5 half-pel grid and averages it with the centre candidate.
module quat_interp_pipe #(
    parameter int PIX_W = 8,
    parameter int LANES = 4,
    parameter int ROWS  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 best,
    input  logic                       rnd_mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*9*PIX_W-1:0]   int_pix,
    input  logic [LANES*9*PIX_W-1:0]   half_cand,
    input  logic [LANES*8*PIX_W-1:0]   half_pix,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*9*PIX_W-1:0]   quat,
    output logic                       out_last,
    output logic                       done,
    output logic                       busy,
    output logic                       best_err
);

    localparam int VW    = LANES * 9 * PIX_W;
    localparam int GW    = 25 * PIX_W;
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_best;
    logic               r_rnd;
    logic               r_best_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_s1_valid;
    logic               r_s1_last;
    logic [VW-1:0]      r_s1_nb;
    logic               r_out_valid;
    logic               r_out_last;
    logic [VW-1:0]      r_quat;
    logic               r_done;

    logic               w_advance;
    logic               w_accept;
    logic               w_out_xfer;
    logic               w_start_ok;
    logic               w_last_in;
    logic [GW-1:0]      w_grid;
    logic [VW-1:0]      w_sel;
    logic [VW-1:0]      w_avg;

    // Rounding average at PIX_W+1 bits; the shifted sum always fits PIX_W bits.
    function automatic logic [PIX_W-1:0] avg2(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] c,
        input logic             trunc
    );
        logic [PIX_W:0] sum;
        sum = {1'b0, a} + {1'b0, c} + {{PIX_W{1'b0}}, ~trunc};
        return sum[PIX_W:1];
    endfunction

    // 5x5 half-pel grid of one lane; int_pix[4] overrides the inner centre.
    function automatic logic [GW-1:0] build_grid(
        input logic [9*PIX_W-1:0] ip,
        input logic [9*PIX_W-1:0] hc,
        input logic [8*PIX_W-1:0] hp
    );
        logic [GW-1:0] g;
        g = '0;
        for (int k = 0; k < 9; k++) begin
            g[((1 + k / 3) * 5 + 1 + k % 3) * PIX_W +: PIX_W] = hc[k*PIX_W +: PIX_W];
        end
        for (int k = 0; k < 9; k++) begin
            g[((2 * (k / 3)) * 5 + 2 * (k % 3)) * PIX_W +: PIX_W] = ip[k*PIX_W +: PIX_W];
        end
        g[ 1*PIX_W +: PIX_W] = hp[0*PIX_W +: PIX_W];
        g[ 3*PIX_W +: PIX_W] = hp[1*PIX_W +: PIX_W];
        g[ 9*PIX_W +: PIX_W] = hp[2*PIX_W +: PIX_W];
        g[19*PIX_W +: PIX_W] = hp[3*PIX_W +: PIX_W];
        g[23*PIX_W +: PIX_W] = hp[4*PIX_W +: PIX_W];
        g[21*PIX_W +: PIX_W] = hp[5*PIX_W +: PIX_W];
        g[15*PIX_W +: PIX_W] = hp[6*PIX_W +: PIX_W];
        g[ 5*PIX_W +: PIX_W] = hp[7*PIX_W +: PIX_W];
        return g;
    endfunction

    // A stalled output register freezes both stages together.
    assign w_advance  = !r_out_valid || out_ready;
    assign in_ready   = (r_state == ST_RUN) && w_advance;
    assign w_accept   = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_last_in  = (r_cnt == LAST_CNT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
                else       w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (w_accept && w_last_in) w_state_nxt = ST_DRAIN;
                else                       w_state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (w_out_xfer && r_out_last) w_state_nxt = ST_IDLE;
                else                          w_state_nxt = ST_DRAIN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Block parameters latched at start, plus the input beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best     <= 4'd0;
            r_rnd      <= 1'b0;
            r_best_err <= 1'b0;
            r_cnt      <= '0;
        end else if (w_start_ok) begin
            r_best     <= (best > 4'd8) ? 4'd0 : best;
            r_rnd      <= rnd_mode;
            r_best_err <= (best > 4'd8);
            r_cnt      <= '0;
        end else if (w_accept && !w_last_in) begin
            r_cnt      <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Neighbour selection; slot 4 carries the chosen half-pel candidate itself
    always_comb begin
        w_grid = '0;
        w_sel  = '0;
        for (int l = 0; l < LANES; l++) begin
            w_grid = build_grid(int_pix[l*9*PIX_W +: 9*PIX_W],
                                half_cand[l*9*PIX_W +: 9*PIX_W],
                                half_pix[l*8*PIX_W +: 8*PIX_W]);
            for (int j = 0; j < 9; j++) begin
                if (j == 4) begin
                    w_sel[(l*9+j)*PIX_W +: PIX_W] =
                        half_cand[(l*9 + int'(r_best))*PIX_W +: PIX_W];
                end else begin
                    w_sel[(l*9+j)*PIX_W +: PIX_W] =
                        w_grid[((int'(r_best) / 3 + j / 3) * 5
                                + int'(r_best) % 3 + j % 3) * PIX_W +: PIX_W];
                end
            end
        end
    end

    // Averaging of every neighbour against the centre candidate
    always_comb begin
        w_avg = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < 9; j++) begin
                if (j == 4) begin
                    w_avg[(l*9+j)*PIX_W +: PIX_W] = r_s1_nb[(l*9+4)*PIX_W +: PIX_W];
                end else begin
                    w_avg[(l*9+j)*PIX_W +: PIX_W] =
                        avg2(r_s1_nb[(l*9+j)*PIX_W +: PIX_W],
                             r_s1_nb[(l*9+4)*PIX_W +: PIX_W], r_rnd);
                end
            end
        end
    end

    // Two-stage datapath; data registers only load on a valid beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_nb     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_quat      <= '0;
        end else if (w_advance) begin
            r_s1_valid  <= w_accept;
            r_s1_last   <= w_accept && w_last_in;
            if (w_accept) begin
                r_s1_nb <= w_sel;
            end
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_quat  <= w_avg;
            end
        end
    end

    // Completion pulse lands on the first IDLE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && w_out_xfer && r_out_last;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign quat      = r_quat;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);
    assign best_err  = r_best_err;

endmodule

// File: tb/tb_quat_interp_pipe.sv
// Randomized and directed bench for quat_interp_pipe, scored against a grid-level
// reference model computed directly from the interpolation rules.
module tb_quat_interp_pipe;

    localparam int PIX_W = 8;
    localparam int LANES = 4;
    localparam int ROWS  = 4;
    localparam int VW    = LANES * 9 * PIX_W;
    localparam int HW    = LANES * 8 * PIX_W;
    localparam int RR[8] = '{0, 0, 1, 3, 4, 4, 3, 1};
    localparam int RC[8] = '{1, 3, 4, 4, 3, 1, 0, 0};

    logic          clk = 1'b0;
    logic          rst, start, rnd_mode, in_valid, in_ready;
    logic          out_valid, out_ready, out_last, done, busy, best_err;
    logic [3:0]    best;
    logic [VW-1:0] int_pix, half_cand, quat;
    logic [HW-1:0] half_pix;

    always #5 clk = ~clk;

    quat_interp_pipe #(.PIX_W(PIX_W), .LANES(LANES), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .best(best), .rnd_mode(rnd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .int_pix(int_pix),
        .half_cand(half_cand), .half_pix(half_pix), .out_valid(out_valid),
        .out_ready(out_ready), .quat(quat), .out_last(out_last), .done(done),
        .busy(busy), .best_err(best_err)
    );

    typedef struct {
        logic [VW-1:0] q;
        bit            last;
        int            acyc;
    } beat_t;

    int            checks = 0;
    int            errors = 0;
    int            ip_a[LANES][9];
    int            hc_a[LANES][9];
    int            hp_a[LANES][8];
    beat_t         sb[$];
    int            cyc_n = 0;
    int            blk_acc = 0;
    bit            lat_chk = 1'b0;
    bit            exp_done = 1'b0;
    int            cur_best = 0;
    bit            cur_rnd = 1'b0;
    logic [VW-1:0] last_q = '0;
    logic [VW-1:0] prev_q = '0;
    bit            prev_stall = 1'b0;
    logic          prev_last_o = 1'b0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: build the 5x5 half-pel grid, pick the window, average with the candidate.
    function automatic logic [VW-1:0] model(input int b_in, input bit rnd);
        int            g[5][5];
        int            b, c, v;
        logic [VW-1:0] r;
        r = '0;
        b = (b_in > 8) ? 0 : b_in;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 9; k++) begin
                g[2*(k/3)][2*(k%3)] = ip_a[l][k];
                if (k != 4) g[1+k/3][1+k%3] = hc_a[l][k];
            end
            for (int m = 0; m < 8; m++) g[RR[m]][RC[m]] = hp_a[l][m];
            c = hc_a[l][b];
            for (int j = 0; j < 9; j++) begin
                if (j == 4) v = c;
                else        v = (g[b/3 + j/3][b%3 + j%3] + c + (rnd ? 0 : 1)) / 2;
                r[(l*9+j)*PIX_W +: PIX_W] = PIX_W'(v);
            end
        end
        return r;
    endfunction

    task automatic gen(input int mode);
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 9; k++) begin
                ip_a[l][k] = $urandom_range(0, 255);
                hc_a[l][k] = $urandom_range(0, 255);
                if (mode == 1) hc_a[l][k] = (k == 4) ? 20 : 10;
                int_pix[(l*9+k)*PIX_W +: PIX_W]   = PIX_W'(ip_a[l][k]);
            end
            if (mode == 2) begin
                ip_a[l][0] = 255;
                hc_a[l][0] = 0;
                int_pix[(l*9)*PIX_W +: PIX_W] = PIX_W'(ip_a[l][0]);
            end
            for (int k = 0; k < 9; k++) half_cand[(l*9+k)*PIX_W +: PIX_W] = PIX_W'(hc_a[l][k]);
            for (int k = 0; k < 8; k++) begin
                hp_a[l][k] = $urandom_range(0, 255);
                half_pix[(l*8+k)*PIX_W +: PIX_W] = PIX_W'(hp_a[l][k]);
            end
        end
    endtask

    // One clock: score the handshakes just before the edge, check done just after it.
    task automatic cyc();
        bit    acc, xfer;
        beat_t e;
        #1;
        if (prev_stall) begin
            chk_bit("hold_valid", out_valid, 1'b1);
            chk_vec("hold_quat", quat, prev_q);
            chk_bit("hold_last", out_last, prev_last_o);
        end
        if (out_valid === 1'b1 && out_ready === 1'b0) chk_bit("stall_in_ready", in_ready, 1'b0);
        acc  = !rst && in_valid && in_ready;
        xfer = !rst && out_valid && out_ready;
        if (acc) begin
            checks++;
            assert (blk_acc < ROWS) else begin
                errors++;
                $error("FAIL extra_beat observed=%0d expected<%0d", blk_acc + 1, ROWS + 1);
            end
            e.q = model(cur_best, cur_rnd);
            e.last = (blk_acc == ROWS - 1);
            e.acyc = cyc_n;
            sb.push_back(e);
            blk_acc++;
        end
        if (xfer) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL spurious_beat observed=%0d expected=0", 1);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_vec("quat", quat, e.q);
                chk_bit("out_last", out_last, e.last);
                if (lat_chk) chk_int("latency", cyc_n - e.acyc, 2);
                last_q = quat;
            end
        end
        exp_done    = xfer && out_last;
        prev_stall  = !rst && out_valid && !out_ready;
        prev_q      = quat;
        prev_last_o = out_last;
        @(posedge clk);
        #1;
        cyc_n++;
        chk_bit("done", done, exp_done);
    endtask

    task automatic run_block(input int b, input bit rnd, input int mode, input int pv,
                             input int pr, input bit mid_start, input bit stall3);
        int n, stall_left;
        bit stalled;
        n = 0; stall_left = 0; stalled = 1'b0;
        lat_chk = (pr == 100) && !stall3;
        start = 1'b1; best = 4'(b); rnd_mode = rnd; in_valid = 1'b0; out_ready = 1'b1;
        cur_best = b; cur_rnd = rnd; blk_acc = 0;
        cyc();
        start = 1'b0;
        chk_bit("busy_run", busy, 1'b1);
        chk_bit("best_err_latch", best_err, b > 8);
        while (done !== 1'b1 && n < 300) begin
            gen(mode);
            in_valid = ($urandom_range(0, 99) < pv);
            if (stall3 && !stalled && blk_acc == 2) begin
                stalled = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < pr);
            if (stall_left > 0) stall_left--;
            if (mid_start) begin
                start = $urandom_range(0, 1);
                best = 4'($urandom_range(0, 15));
                rnd_mode = $urandom_range(0, 1);
            end
            cyc();
            n++;
        end
        chk_bit("done_seen", done, 1'b1);
        chk_int("beats", blk_acc, ROWS);
        chk_bit("idle_busy", busy, 1'b0);
        chk_bit("idle_in_ready", in_ready, 1'b0);
        chk_int("sb_empty", sb.size(), 0);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; best = 4'(b);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; best = 4'd0; rnd_mode = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; int_pix = '0; half_cand = '0; half_pix = '0;
        repeat (3) cyc();
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_out_last", out_last, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_best_err", best_err, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_vec("rst_quat", quat, '0);
        rst = 1'b0;
        cyc();

        // Uniform candidates: centre 20, neighbours average to 15
        run_block(4, 1'b0, 1, 100, 100, 1'b0, 1'b0);
        chk_int("uni_centre", int'(last_q[4*PIX_W +: PIX_W]), 20);
        chk_int("uni_edge", int'(last_q[0 +: PIX_W]), 15);

        // Saturating corner, rounding then truncating; second start hits the done cycle
        run_block(0, 1'b0, 2, 100, 100, 1'b0, 1'b0);
        chk_int("corner_round", int'(last_q[0 +: PIX_W]), 128);
        run_block(0, 1'b1, 2, 100, 100, 1'b0, 1'b0);
        chk_int("corner_trunc", int'(last_q[0 +: PIX_W]), 127);

        // Out-of-range best behaves as 0 and flags the error until the next start
        run_block(9, 1'b0, 0, 100, 100, 1'b0, 1'b0);
        chk_bit("best_err_sticky", best_err, 1'b1);
        run_block(2, 1'b0, 0, 100, 100, 1'b0, 1'b0);
        chk_bit("best_err_clear", best_err, 1'b0);

        // Three-cycle downstream stall mid-block
        run_block(5, 1'b0, 0, 100, 100, 1'b0, 1'b1);

        // Reset after two accepted beats
        start = 1'b1; best = 4'd3; rnd_mode = 1'b0; cur_best = 3; cur_rnd = 1'b0; blk_acc = 0;
        lat_chk = 1'b1;
        cyc();
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; n = 0;
        while (blk_acc < 2 && n < 50) begin
            gen(0);
            cyc();
            n++;
        end
        chk_int("rst_mid_acc", blk_acc, 2);
        rst = 1'b1;
        cyc();
        chk_bit("rst_mid_out_valid", out_valid, 1'b0);
        chk_bit("rst_mid_busy", busy, 1'b0);
        chk_bit("rst_mid_in_ready", in_ready, 1'b0);
        rst = 1'b0; in_valid = 1'b0; sb.delete(); blk_acc = 0;
        repeat (4) cyc();
        chk_bit("rst_mid_flushed", out_valid, 1'b0);
        run_block(7, 1'b1, 0, 100, 100, 1'b0, 1'b0);

        // start pulses during RUN/DRAIN are ignored
        run_block(6, 1'b0, 0, 100, 100, 1'b1, 1'b0);

        // Random bubbles and backpressure
        for (int i = 0; i < 8; i++) begin
            run_block($urandom_range(0, 10), $urandom_range(0, 1), 0, 60, 60, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
